// File: rtl/wb_select_stage.sv
// wb_select_stage
//   Registered writeback stage. Selects load data, link value or ALU result
//   for an accepted MEM/WB instruction and drives a single-port register-file
//   write one cycle later. A load whose data has not returned parks the stage
//   in WAIT_MEM, back-pressuring the pipeline until data, flush or timeout.
//
// Ports
//   clk, rst          clock / synchronous active-high reset
//   in_valid/in_ready instruction handshake (ready only in IDLE)
//   in_lw, in_jal,    instruction kind and write request
//   in_wr_en, in_dst  destination register
//   in_alu_data,      candidate writeback values
//   in_link_data
//   mem_rvalid,       load data return
//   mem_rdata
//   flush             cancel pending and incoming instruction
//   stall             in_valid & ~in_ready
//   rf_we/rf_waddr/   registered register-file write port
//   rf_wdata
//   err_timeout       one-cycle pulse when a load is abandoned
//   stall_cnt         saturating count of cycles spent in WAIT_MEM
module wb_select_stage #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RADDR_W     = 4,
  parameter int unsigned LINK_REG    = 15,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_lw,
  input  logic               in_jal,
  input  logic               in_wr_en,
  input  logic [RADDR_W-1:0] in_dst,
  input  logic [DATA_W-1:0]  in_alu_data,
  input  logic [DATA_W-1:0]  in_link_data,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               flush,
  output logic               stall,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TW-1:0]      tcnt;
  logic [RADDR_W-1:0] pend_dst;

  logic               accept;
  logic               tcnt_done;
  logic               wr_now;
  logic [RADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               load_wait;
  logic               abort;

  assign in_ready  = (state == IDLE);
  assign stall     = in_valid & ~in_ready;
  assign accept    = in_valid & in_ready & ~flush;
  // tcnt holds the number of WAIT_MEM cycles including the current one
  assign tcnt_done = (tcnt >= TW'(MEM_TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && in_lw && !mem_rvalid) state_nxt = WAIT_MEM;
      end
      WAIT_MEM: begin
        // flush, data return and timeout all end the wait
        if (flush || mem_rvalid || tcnt_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / write-selection logic
  always_comb begin
    wr_now    = 1'b0;
    wr_addr   = in_dst;
    wr_data   = in_alu_data;
    load_wait = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (in_lw) begin
            if (mem_rvalid) begin
              wr_now  = 1'b1;
              wr_addr = in_dst;
              wr_data = mem_rdata;
            end else begin
              load_wait = 1'b1;
            end
          end else begin
            wr_now = in_jal | in_wr_en;
            if (in_jal) begin
              wr_addr = RADDR_W'(LINK_REG);
              wr_data = in_link_data;
            end
          end
        end
      end
      WAIT_MEM: begin
        // flush beats data, data beats timeout
        if (!flush) begin
          if (mem_rvalid) begin
            wr_now  = 1'b1;
            wr_addr = pend_dst;
            wr_data = mem_rdata;
          end else if (tcnt_done) begin
            abort = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      err_timeout <= 1'b0;
      stall_cnt   <= '0;
      tcnt        <= '0;
      pend_dst    <= '0;
    end else begin
      rf_we       <= wr_now;
      err_timeout <= abort;
      if (wr_now) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
      if (load_wait) begin
        pend_dst <= in_dst;
        tcnt     <= TW'(1);
      end else if (state == WAIT_MEM && !flush && !mem_rvalid && !tcnt_done) begin
        tcnt <= tcnt + 1'b1;
      end
      if (state == WAIT_MEM && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_lw;
  logic        in_jal;
  logic        in_wr_en;
  logic [3:0]  in_dst;
  logic [15:0] in_alu_data;
  logic [15:0] in_link_data;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        flush;
  logic        stall;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        err_timeout;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  int stall_seen;

  wb_select_stage #(
    .DATA_W(16),
    .RADDR_W(4),
    .LINK_REG(15),
    .MEM_TIMEOUT(4),
    .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lw(in_lw), .in_jal(in_jal), .in_wr_en(in_wr_en), .in_dst(in_dst),
    .in_alu_data(in_alu_data), .in_link_data(in_link_data),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_timeout(err_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_lw = 0; in_jal = 0; in_wr_en = 0; in_dst = 0;
    in_alu_data = 0; in_link_data = 0; mem_rvalid = 0; mem_rdata = 0; flush = 0;
  endtask

  task automatic instr(input logic lw, input logic jal, input logic we, input logic [3:0] dst,
                       input logic [15:0] alu, input logic [15:0] link);
    in_valid = 1; in_lw = lw; in_jal = jal; in_wr_en = we; in_dst = dst;
    in_alu_data = alu; in_link_data = link;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_ready", in_ready, 1);

    // ALU write, then back-to-back
    instr(0, 0, 1, 4'd3, 16'h1234, 16'h0);
    tick();
    chk("alu_we", rf_we, 1);
    chk("alu_waddr", rf_waddr, 3);
    chk("alu_wdata", rf_wdata, 16'h1234);
    chk("alu_ready", in_ready, 1);
    instr(0, 0, 1, 4'd4, 16'h5555, 16'h0);
    tick();
    chk("b2b_waddr", rf_waddr, 4);
    chk("b2b_wdata", rf_wdata, 16'h5555);

    // accepted instruction with no write request
    instr(0, 0, 0, 4'd9, 16'h7777, 16'h0);
    tick();
    chk("nowr_we", rf_we, 0);
    chk("nowr_hold_addr", rf_waddr, 4);
    chk("nowr_hold_data", rf_wdata, 16'h5555);

    // jal uses link register and link data
    instr(0, 1, 0, 4'd2, 16'h9999, 16'h0040);
    tick();
    chk("jal_we", rf_we, 1);
    chk("jal_waddr", rf_waddr, 15);
    chk("jal_wdata", rf_wdata, 16'h0040);

    // lw beats jal, same-cycle data
    instr(1, 1, 0, 4'd2, 16'h9999, 16'h0040);
    mem_rvalid = 1; mem_rdata = 16'hBEEF;
    tick();
    chk("lw_waddr", rf_waddr, 2);
    chk("lw_wdata", rf_wdata, 16'hBEEF);
    chk("lw_ready", in_ready, 1);

    // stray rvalid in IDLE is ignored
    idle_inputs();
    mem_rvalid = 1; mem_rdata = 16'h1111;
    tick();
    chk("stray_we", rf_we, 0);
    chk("stray_wdata", rf_wdata, 16'hBEEF);

    // delayed load to r5, data 3 cycles later; next instruction waits
    idle_inputs();
    instr(1, 0, 0, 4'd5, 16'h0, 16'h0);
    tick();
    instr(0, 0, 1, 4'd6, 16'h0606, 16'h0);
    stall_seen = 0;
    chk("dl_ready", in_ready, 0);
    chk("dl_we0", rf_we, 0);
    if (stall) stall_seen++;
    tick();
    if (stall) stall_seen++;
    tick();
    mem_rvalid = 1; mem_rdata = 16'hA5A5;
    if (stall) stall_seen++;
    tick();
    mem_rvalid = 0;
    chk("dl_stall_cycles", stall_seen, 3);
    chk("dl_cnt", stall_cnt, 3);
    chk("dl_we", rf_we, 1);
    chk("dl_waddr", rf_waddr, 5);
    chk("dl_wdata", rf_wdata, 16'hA5A5);
    chk("dl_stall_off", stall, 0);
    tick();
    chk("dl_next_waddr", rf_waddr, 6);
    chk("dl_next_wdata", rf_wdata, 16'h0606);

    // timeout after 4 WAIT_MEM cycles
    instr(1, 0, 0, 4'd7, 16'h0, 16'h0);
    tick();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("to_we", rf_we, 0);
      chk("to_err", err_timeout, (i == 4) ? 1 : 0);
      chk("to_ready", in_ready, (i == 4) ? 1 : 0);
    end
    tick();
    chk("to_err_pulse", err_timeout, 0);
    chk("to_cnt", stall_cnt, 7);

    // data arriving in the timeout cycle wins
    instr(1, 0, 0, 4'd12, 16'h0, 16'h0);
    tick();
    idle_inputs();
    tick(); tick(); tick();
    mem_rvalid = 1; mem_rdata = 16'hC3C3;
    tick();
    mem_rvalid = 0;
    chk("tor_we", rf_we, 1);
    chk("tor_waddr", rf_waddr, 12);
    chk("tor_wdata", rf_wdata, 16'hC3C3);
    chk("tor_err", err_timeout, 0);
    chk("tor_cnt", stall_cnt, 11);

    // flush with rvalid mid-load
    instr(1, 0, 0, 4'd8, 16'h0, 16'h0);
    tick();
    idle_inputs();
    tick(); tick();
    flush = 1; mem_rvalid = 1; mem_rdata = 16'hDEAD;
    tick();
    flush = 0; mem_rvalid = 0;
    chk("fl_we", rf_we, 0);
    chk("fl_err", err_timeout, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_wdata", rf_wdata, 16'hC3C3);
    chk("fl_cnt", stall_cnt, 14);
    tick();
    chk("fl_err_late", err_timeout, 0);

    // flush in IDLE drops the incoming instruction
    instr(0, 0, 1, 4'd9, 16'h0909, 16'h0);
    flush = 1;
    tick();
    flush = 0;
    idle_inputs();
    chk("fli_we", rf_we, 0);
    chk("fli_waddr", rf_waddr, 12);

    // reset mid-load
    instr(1, 0, 0, 4'd10, 16'h0, 16'h0);
    tick();
    idle_inputs();
    chk("rl_ready0", in_ready, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("rl_we", rf_we, 0);
    chk("rl_waddr", rf_waddr, 0);
    chk("rl_wdata", rf_wdata, 0);
    chk("rl_cnt", stall_cnt, 0);
    chk("rl_err", err_timeout, 0);
    chk("rl_ready", in_ready, 1);
    instr(0, 0, 1, 4'd11, 16'h0B0B, 16'h0);
    tick();
    idle_inputs();
    chk("rl_alu_we", rf_we, 1);
    chk("rl_alu_waddr", rf_waddr, 11);
    chk("rl_alu_wdata", rf_wdata, 16'h0B0B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
